// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Handshake and control bundle between a requester and the shift_seq_ctrl
// sequencer.
//   START  : transaction request (requester -> sequencer)
//   LEN    : number of shifts requested, LW bits
//   FILL   : serial fill bit for the transaction
//   ABORT  : synchronous cancel of the current transaction
//   LD     : load select to the shift register
//   SH     : shift select to the shift register
//   SER    : serial input to the shift register (latched FILL)
//   BUSY   : sequencer is not idle
//   DONE   : one-cycle completion pulse
//   REMAIN : shifts remaining, including the current SH cycle
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if #(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
);
    logic          START;
    logic [LW-1:0] LEN;
    logic          FILL;
    logic          ABORT;
    logic          LD;
    logic          SH;
    logic          SER;
    logic          BUSY;
    logic          DONE;
    logic [LW-1:0] REMAIN;

    // Requester side: drives the request, observes the sequencer outputs.
    modport master (
        output START, LEN, FILL, ABORT,
        input  LD, SH, SER, BUSY, DONE, REMAIN
    );

    // Sequencer side: observes the request, drives the shift-register controls.
    modport slave (
        input  START, LEN, FILL, ABORT,
        output LD, SH, SER, BUSY, DONE, REMAIN
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Moore sequencer that drives a load/shift pair for an N-bit shift register.
// A transaction is: one LOAD cycle, REMAIN shift cycles, one FIN cycle with a
// DONE pulse, then back to IDLE. ABORT cancels at the next edge without DONE.
// Ports:
//   CLK  : system clock, rising edge
//   RSTn : asynchronous active-low reset
//   bus  : shift_seq_ctrl_if.slave (START/LEN/FILL/ABORT in,
//          LD/SH/SER/BUSY/DONE/REMAIN out)
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic             CLK,
    input  logic             RSTn,
    shift_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [LW-1:0] N_LW    = LW'(N);
    localparam logic [LW-1:0] ZERO_LW = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_LW  = LW'(1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [LW-1:0] remain_r;
    logic [LW-1:0] remain_nxt_s;
    logic          fill_r;
    logic          fill_nxt_s;
    logic [LW-1:0] len_clamp_s;
    logic          start_ok_s;

    // ABORT wins over START in IDLE, so a simultaneous request is dropped.
    assign start_ok_s  = bus.START & ~bus.ABORT;
    assign len_clamp_s = (bus.LEN > N_LW) ? N_LW : bus.LEN;

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bus.ABORT) begin
                    state_nxt_s = S_IDLE;
                end else if (remain_r != ZERO_LW) begin
                    state_nxt_s = S_SHIFT;
                end else begin
                    state_nxt_s = S_FIN;
                end
            end
            S_SHIFT: begin
                // <= 1 rather than == 1 so a corrupted zero count cannot stall here.
                if (bus.ABORT) begin
                    state_nxt_s = S_IDLE;
                end else if (remain_r <= ONE_LW) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_SHIFT;
                end
            end
            S_FIN: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Next value of the shift counter and the latched fill bit.
    always_comb begin
        remain_nxt_s = remain_r;
        fill_nxt_s   = fill_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    remain_nxt_s = len_clamp_s;
                    fill_nxt_s   = bus.FILL;
                end else begin
                    remain_nxt_s = remain_r;
                    fill_nxt_s   = fill_r;
                end
            end
            S_LOAD: begin
                if (bus.ABORT) begin
                    remain_nxt_s = ZERO_LW;
                end else begin
                    remain_nxt_s = remain_r;
                end
            end
            S_SHIFT: begin
                if (bus.ABORT || (remain_r == ZERO_LW)) begin
                    remain_nxt_s = ZERO_LW;
                end else begin
                    remain_nxt_s = remain_r - ONE_LW;
                end
            end
            S_FIN: begin
                remain_nxt_s = ZERO_LW;
            end
            default: begin
                remain_nxt_s = ZERO_LW;
                fill_nxt_s   = 1'b0;
            end
        endcase
    end

    // Datapath registers: shift counter and latched fill bit.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            remain_r <= ZERO_LW;
            fill_r   <= 1'b0;
        end else begin
            remain_r <= remain_nxt_s;
            fill_r   <= fill_nxt_s;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        bus.LD     = 1'b0;
        bus.SH     = 1'b0;
        bus.BUSY   = 1'b0;
        bus.DONE   = 1'b0;
        bus.SER    = 1'b0;
        bus.REMAIN = remain_r;
        case (state_r)
            S_IDLE: begin
                bus.BUSY = 1'b0;
            end
            S_LOAD: begin
                bus.LD   = 1'b1;
                bus.BUSY = 1'b1;
                bus.SER  = fill_r;
            end
            S_SHIFT: begin
                bus.SH   = 1'b1;
                bus.BUSY = 1'b1;
                bus.SER  = fill_r;
            end
            S_FIN: begin
                bus.DONE = 1'b1;
                bus.BUSY = 1'b1;
                bus.SER  = fill_r;
            end
            default: begin
                bus.BUSY = 1'b0;
            end
        endcase
    end

endmodule
